// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between fetch (I) and load/store (D) requesters.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic [2:0]            d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [1:0]            grant
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2;
  localparam logic [3:0] MAXB = 4'(MAX_BURST);
  logic [1:0] state_q, state_d, grant_q, grant_d;
  logic [3:0] burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0] we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, i_rdata_q, d_rdata_q;
  logic arb, ip, dp, pick_d, pick_i;
  always_comb begin
    arb = state_q == IDLE || state_q == ACK;
    // the master acked this cycle may still be holding its req
    ip = i_req && !(state_q == ACK && grant_q[0]);
    dp = d_req && !(state_q == ACK && grant_q[1]);
    pick_d = arb && dp && (!ip || burst_q != MAXB);
    pick_i = arb && ip && !pick_d;
    state_d = state_q == ACCESS ? ACK : (pick_d || pick_i) ? ACCESS : IDLE;
    grant_d = pick_d ? 2'b10 : pick_i ? 2'b01 : grant_q;
    burst_d = pick_i ? 4'd0 : !pick_d ? burst_q : !i_req ? 4'd0 : burst_q == MAXB ? burst_q : burst_q + 4'd1;
    addr_d = pick_d ? d_addr : pick_i ? i_addr : addr_q;
    we_d = pick_d ? d_we : 3'b000;
    wdata_d = pick_d ? d_wdata : wdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      burst_q <= 4'd0;
      addr_q <= '0;
      we_q <= 3'b000;
      wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      if (state_q == ACCESS && grant_q[0]) i_rdata_q <= mem_rdata;
      if (state_q == ACCESS && grant_q[1]) d_rdata_q <= mem_rdata;
    end
  end
  assign i_ack = state_q == ACK && grant_q[0];
  assign d_ack = state_q == ACK && grant_q[1];
  assign busy = state_q != IDLE;
  assign grant = grant_q;
  assign mem_addr = addr_q;
  assign mem_we = we_q;
  assign mem_wdata = wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and random checks of mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;
  localparam int MB = 4;
  logic clk = 1'b0, rst;
  logic i_req, d_req, i_ack, d_ack, busy;
  logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0] d_we, mem_we;
  logic [1:0] grant;
  logic [31:0] mem [16];
  int checks = 0, errors = 0;
  int m_own, m_age, m_burst;
  logic [31:0] e_addr, e_wdata, e_ir, e_dr;
  logic [2:0] e_we;
  logic [31:0] mm [16];

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant(grant));

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int k);
    return k == 4 ? 32'hDEADBEEF : 32'hC0DE0000 | 32'(k);
  endfunction

  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < 16; k++) mem[k] <= init_word(k);
    else if (mem_we != 3'b000) mem[mem_addr[5:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // m_age counts cycles since the current transaction was granted (0 = no transaction)
  task automatic model_reset();
    m_own = 0; m_age = 0; m_burst = 0;
    e_addr = 0; e_wdata = 0; e_ir = 0; e_dr = 0; e_we = 0;
    for (int k = 0; k < 16; k++) mm[k] = init_word(k);
  endtask

  task automatic model_step();
    logic pi, pd;
    if (rst) begin model_reset(); return; end
    if (m_age == 1) begin
      if (m_own == 1) e_ir = mm[e_addr[5:2]]; else e_dr = mm[e_addr[5:2]];
      if (e_we != 0) mm[e_addr[5:2]] = e_wdata;
      m_age = 2;
    end else begin
      pi = i_req && !(m_age == 2 && m_own == 1);
      pd = d_req && !(m_age == 2 && m_own == 2);
      if (pd && (!pi || m_burst < MB)) begin
        m_burst = i_req ? (m_burst + 1 > MB ? MB : m_burst + 1) : 0;
        m_own = 2; e_addr = d_addr; e_we = d_we; e_wdata = d_wdata; m_age = 1;
      end else if (pi) begin
        m_burst = 0; m_own = 1; e_addr = i_addr; e_we = 0; m_age = 1;
      end else m_age = 0;
    end
  endtask

  task automatic check_all();
    logic xi, xd;
    xi = m_age == 2 && m_own == 1;
    xd = m_age == 2 && m_own == 2;
    chk("i_ack", 32'(i_ack), 32'(xi));
    chk("d_ack", 32'(d_ack), 32'(xd));
    chk("busy", 32'(busy), 32'(m_age != 0));
    chk("grant", 32'(grant), m_own == 2 ? 32'd2 : m_own == 1 ? 32'd1 : 32'd0);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_we", 32'(mem_we), m_age == 1 ? 32'(e_we) : 32'd0);
    if (m_age == 1 && e_we != 0) chk("mem_wdata", mem_wdata, e_wdata);
    if (xi) chk("i_rdata", i_rdata, e_ir);
    if (xd && e_we == 0) chk("d_rdata", d_rdata, e_dr);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; d_we = 0; d_wdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    // single fetch
    i_req = 1; i_addr = 32'h10;
    cyc(); chk("fetch_addr", mem_addr, 32'h10);
    cyc(); chk("fetch_ack", 32'(i_ack), 32'd1); chk("fetch_data", i_rdata, 32'hDEADBEEF);
    i_req = 0;
    cyc(); chk("fetch_idle", 32'(busy), 32'd0);
    // store then load
    d_req = 1; d_we = 3'b001; d_addr = 32'h10000004; d_wdata = 32'h12345678;
    cyc(); chk("store_we", 32'(mem_we), 32'd1);
    cyc(); chk("store_we_off", 32'(mem_we), 32'd0); chk("store_ack", 32'(d_ack), 32'd1);
    d_req = 0;
    cyc();
    d_req = 1; d_we = 3'b000;
    cyc(); cyc(); chk("load_ack", 32'(d_ack), 32'd1); chk("load_data", d_rdata, 32'h12345678);
    d_req = 0;
    cyc();
    // asynchronous reset during a write access
    d_req = 1; d_we = 3'b001; d_addr = 32'h10000008; d_wdata = 32'hCAFEF00D;
    cyc();
    #1 rst = 1'b1;
    #1;
    chk("arst_mem_we", 32'(mem_we), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'd0);
    chk("arst_d_rdata", d_rdata, 32'd0);
    chk("arst_acks", 32'({i_ack, d_ack}), 32'd0);
    model_reset();
    d_req = 0;
    cyc();
    @(negedge clk) rst = 1'b0;
    repeat (3) begin cyc(); chk("arst_no_ack", 32'(d_ack), 32'd0); end
    // simultaneous requests at reset release
    rst = 1'b1; model_reset();
    i_req = 1; i_addr = 32'h14; d_req = 1; d_we = 3'b000; d_addr = 32'h10000004;
    @(negedge clk) rst = 1'b0;
    cyc(); chk("sim_grant_d", 32'(grant), 32'd2);
    cyc(); chk("sim_d_ack", 32'(d_ack), 32'd1);
    d_req = 0;
    cyc(); chk("sim_grant_i", 32'(grant), 32'd1); chk("sim_no_idle", 32'(busy), 32'd1);
    cyc(); chk("sim_i_ack", 32'(i_ack), 32'd1);
    i_req = 0;
    cyc();
    // burst limit: D wins MB times against a pending I, then I is forced
    for (int k = 0; k < MB; k++) begin
      i_req = 1; d_req = 1; d_we = 3'b000; d_addr = 32'(k * 4);
      cyc(); chk("burst_d", 32'(grant), 32'd2);
      i_req = 0;
      cyc(); chk("burst_d_ack", 32'(d_ack), 32'd1);
      d_req = 0;
      cyc();
    end
    i_req = 1; i_addr = 32'h20; d_req = 1;
    cyc(); chk("starve_i", 32'(grant), 32'd1);
    cyc(); chk("starve_i_ack", 32'(i_ack), 32'd1);
    i_req = 0;
    cyc(); chk("resume_d", 32'(grant), 32'd2);
    cyc(); d_req = 0;
    cyc();
    i_req = 1; d_req = 1;
    cyc(); chk("burst_cleared", 32'(grant), 32'd2);
    cyc(); d_req = 0;
    cyc(); cyc(); i_req = 0;
    cyc();
    // withdrawal: I pulses only across the closing edge of a D access
    d_req = 1; d_we = 3'b000; d_addr = 32'h1C;
    cyc(); i_req = 1; i_addr = 32'h24;
    cyc(); chk("wd_d_ack", 32'(d_ack), 32'd1);
    i_req = 0; d_req = 0;
    cyc(); chk("wd_mem_we", 32'(mem_we), 32'd0); chk("wd_idle", 32'(busy), 32'd0);
    cyc(); chk("wd_no_i_ack", 32'(i_ack), 32'd0);
    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (i_req) begin
        if (m_age == 2 && m_own == 1) begin i_req = 1'($urandom_range(0, 1)); i_addr = $urandom; end
        else if (!(m_age != 0 && m_own == 1) && $urandom_range(0, 15) == 0) i_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin i_req = 1; i_addr = $urandom; end
      if (d_req) begin
        if (m_age == 2 && m_own == 2) begin
          d_req = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
          d_we = 3'($urandom_range(0, 4) == 0 ? 0 : 1 << $urandom_range(0, 2));
        end else if (!(m_age != 0 && m_own == 2) && $urandom_range(0, 15) == 0) d_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1; d_addr = $urandom; d_wdata = $urandom;
        d_we = 3'($urandom_range(0, 1) == 0 ? 0 : 1 << $urandom_range(0, 2));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
